// File: rtl/uart_tx_mmio_pkg.sv
// rtl/uart_tx_mmio_pkg.sv - shared bus, address, FSM and status-bit constants for uart_tx_mmio
package uart_tx_mmio_pkg;

   localparam logic [1:0]  BUS_NOP        = 2'b10;
   localparam logic [31:0] UART_TXD_ADDR  = 32'h4000_0018;
   localparam logic [31:0] UART_STAT_ADDR = 32'h4000_001C;

   // 3-bit encoding leaves room for PARITY whether or not it is built in
   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } tx_state_e;

   localparam int STAT_BUSY      = 0;
   localparam int STAT_FULL      = 1;
   localparam int STAT_EMPTY     = 2;
   localparam int STAT_OVF       = 3;
   localparam int STAT_COUNT_LSB = 8;

endpackage

// File: rtl/uart_tx_mmio_fifo.sv
// rtl/uart_tx_mmio_fifo.sv - uart_fifo: 8-bit synchronous FIFO, 2**AW entries, head visible on dout
module uart_fifo #(
   parameter int AW = 2
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          push,
   input  logic          pop,
   input  logic [7:0]    din,
   output logic [7:0]    dout,
   output logic          full,
   output logic          empty,
   output logic [AW:0]   count
);

   localparam int DEPTH = 1 << AW;

   logic [7:0]    mem_q [DEPTH];
   logic [AW-1:0] wptr_q, wptr_d;
   logic [AW-1:0] rptr_q, rptr_d;
   logic [AW:0]   count_q, count_d;
   logic          do_push, do_pop;

   always_comb begin
      full    = (count_q == (AW+1)'(DEPTH));
      empty   = (count_q == '0);
      // full is judged on pre-edge state, so a same-cycle pop never admits a push
      do_push = push && !full;
      do_pop  = pop && !empty;
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      count_d = count_q;
      if (do_push) begin
         wptr_d = wptr_q + 1'b1;
      end
      if (do_pop) begin
         rptr_d = rptr_q + 1'b1;
      end
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[wptr_q] <= din;
      end
   end

   assign dout  = mem_q[rptr_q];
   assign count = count_q;

endmodule

// File: rtl/uart_tx_mmio.sv
// rtl/uart_tx_mmio.sv - memory-mapped UART transmitter (TX FIFO + 8N1 serializer)
// Define UART_PARITY_EN to insert an even-parity bit between data and stop bits.
module uart_tx_mmio
   import uart_tx_mmio_pkg::*;
#(
   parameter int          CLKS_PER_BIT = 868,
   parameter int          FIFO_AW      = 2,
   parameter logic [31:0] ADDR_TXD     = UART_TXD_ADDR,
   parameter logic [31:0] ADDR_STAT    = UART_STAT_ADDR
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   input  logic [1:0]  rdop,
   input  logic [1:0]  wrop,
   output logic [31:0] rdata,
   output logic        Tx_Serial
);

   localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);

   tx_state_e       state_q, state_d;
   logic [CW-1:0]   baud_q, baud_d;
   logic [2:0]      bit_q, bit_d;
   logic [7:0]      shift_q, shift_d;
   logic            ovf_q, ovf_d;
`ifdef UART_PARITY_EN
   logic            parity_q, parity_d;
`endif

   logic            wr_txd, wr_stat, rd_stat;
   logic            baud_done;
   logic            fifo_pop, fifo_full, fifo_empty;
   logic [7:0]      fifo_dout;
   logic [FIFO_AW:0] fifo_count;
   logic [31:0]     status;
   logic [23:0]     unused_wdata;

   assign unused_wdata = wdata[31:8];

   always_comb begin
      wr_txd  = (addr == ADDR_TXD)  && (wrop != BUS_NOP);
      wr_stat = (addr == ADDR_STAT) && (wrop != BUS_NOP);
      rd_stat = (addr == ADDR_STAT) && (rdop != BUS_NOP);
   end

   uart_fifo #(
      .AW (FIFO_AW)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (wr_txd),
      .pop   (fifo_pop),
      .din   (wdata[7:0]),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   // a drop on a full FIFO outranks a same-edge clear
   always_comb begin
      ovf_d = ovf_q;
      if (wr_stat) begin
         ovf_d = 1'b0;
      end
      if (wr_txd && fifo_full) begin
         ovf_d = 1'b1;
      end
   end

   always_comb begin
      state_d   = state_q;
      baud_d    = baud_q;
      bit_d     = bit_q;
      shift_d   = shift_q;
      fifo_pop  = 1'b0;
      Tx_Serial = 1'b1;
`ifdef UART_PARITY_EN
      parity_d  = parity_q;
`endif
      baud_done = (baud_q == BAUD_LAST);
      case (state_q)
         ST_IDLE: begin
            if (!fifo_empty) begin
               fifo_pop = 1'b1;
               shift_d  = fifo_dout;
`ifdef UART_PARITY_EN
               parity_d = ^fifo_dout;
`endif
               baud_d   = '0;
               bit_d    = '0;
               state_d  = ST_START;
            end
         end
         ST_START: begin
            Tx_Serial = 1'b0;
            if (baud_done) begin
               baud_d  = '0;
               bit_d   = '0;
               state_d = ST_DATA;
            end else begin
               baud_d = baud_q + 1'b1;
            end
         end
         ST_DATA: begin
            Tx_Serial = shift_q[0];
            if (baud_done) begin
               baud_d  = '0;
               shift_d = {1'b0, shift_q[7:1]};
               if (bit_q == 3'd7) begin
`ifdef UART_PARITY_EN
                  state_d = ST_PARITY;
`else
                  state_d = ST_STOP;
`endif
               end else begin
                  bit_d = bit_q + 1'b1;
               end
            end else begin
               baud_d = baud_q + 1'b1;
            end
         end
`ifdef UART_PARITY_EN
         ST_PARITY: begin
            Tx_Serial = parity_q;
            if (baud_done) begin
               baud_d  = '0;
               state_d = ST_STOP;
            end else begin
               baud_d = baud_q + 1'b1;
            end
         end
`endif
         ST_STOP: begin
            Tx_Serial = 1'b1;
            if (baud_done) begin
               baud_d  = '0;
               state_d = ST_IDLE;
            end else begin
               baud_d = baud_q + 1'b1;
            end
         end
         default: begin
            baud_d  = '0;
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q  <= ST_IDLE;
         baud_q   <= '0;
         bit_q    <= '0;
         shift_q  <= '0;
         ovf_q    <= 1'b0;
`ifdef UART_PARITY_EN
         parity_q <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         baud_q   <= baud_d;
         bit_q    <= bit_d;
         shift_q  <= shift_d;
         ovf_q    <= ovf_d;
`ifdef UART_PARITY_EN
         parity_q <= parity_d;
`endif
      end
   end

   always_comb begin
      status                                    = '0;
      status[STAT_BUSY]                         = (state_q != ST_IDLE);
      status[STAT_FULL]                         = fifo_full;
      status[STAT_EMPTY]                        = fifo_empty;
      status[STAT_OVF]                          = ovf_q;
      status[STAT_COUNT_LSB +: FIFO_AW+1]       = fifo_count;
      rdata = rd_stat ? status : 32'b0;
   end

endmodule

// File: tb/tb_uart_tx_mmio.sv
// tb/tb_uart_tx_mmio.sv - scoreboard bench for uart_tx_mmio (CLKS_PER_BIT=4, FIFO_AW=2; honours UART_PARITY_EN)
module tb_uart_tx_mmio;

   localparam int CPB = 4;
`ifdef UART_PARITY_EN
   localparam int NBITS = 11;
`else
   localparam int NBITS = 10;
`endif
   localparam int FRAME = NBITS * CPB;
   localparam logic [31:0] A_TXD   = 32'h4000_0018;
   localparam logic [31:0] A_STAT  = 32'h4000_001C;
   localparam logic [31:0] A_OTHER = 32'h4000_000C;
   localparam logic [1:0]  NOP     = 2'b10;

   logic        clk   = 1'b0;
   logic        reset = 1'b0;
   logic [31:0] addr  = '0;
   logic [31:0] wdata = '0;
   logic [1:0]  rdop  = NOP;
   logic [1:0]  wrop  = NOP;
   logic [31:0] rdata;
   logic        tx;

   int n_checks  = 0;
   int n_fail    = 0;
   int cyc       = 0;
   int rst_epoch = 0;
   logic [7:0] exp_q[$];
   int         start_cyc[$];

   uart_tx_mmio #(
      .CLKS_PER_BIT (CPB),
      .FIFO_AW      (2)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .addr      (addr),
      .wdata     (wdata),
      .rdop      (rdop),
      .wrop      (wrop),
      .rdata     (rdata),
      .Tx_Serial (tx)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   function automatic logic [NBITS-1:0] frame_bits(input logic [7:0] b);
      logic [NBITS-1:0] f;
      f[0] = 1'b0;
      for (int i = 0; i < 8; i++) f[1+i] = b[i];
`ifdef UART_PARITY_EN
      f[9] = ^b;
`endif
      f[NBITS-1] = 1'b1;
      return f;
   endfunction

   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      addr  = a;
      wdata = d;
      wrop  = 2'b00;
      @(negedge clk);
      wrop  = NOP;
      addr  = '0;
   endtask

   task automatic rd(input logic [31:0] a, input logic [1:0] op, output logic [31:0] v);
      addr = a;
      rdop = op;
      #1;
      v    = rdata;
      rdop = NOP;
      addr = '0;
   endtask

   task automatic wait_drain(input int bound);
      logic [31:0] v;
      int n;
      n = 0;
      v = 32'hFFFF_FFFF;
      while (!((exp_q.size() == 0) && (v[0] == 1'b0)) && (n < bound)) begin
         @(negedge clk);
         rd(A_STAT, 2'b00, v);
         n++;
      end
      check_eq("drain_in_time", 32'(n < bound), 32'd1);
   endtask

   task automatic wave_check(input logic [7:0] b);
      logic [NBITS-1:0] f;
      logic [31:0] v;
      f = frame_bits(b);
      exp_q.push_back(b);
      wr(A_TXD, {24'h0, b});
      check_eq("pre_start_tx", 32'(tx), 32'd1);
      for (int k = 0; k < FRAME; k++) begin
         @(negedge clk);
         check_eq($sformatf("wave_%02h_%0d", b, k), 32'(tx), 32'(f[k / CPB]));
         if (k == 0 || k == FRAME - 1) begin
            rd(A_STAT, 2'b00, v);
            check_eq($sformatf("busy_status_%0d", k), v, 32'h5);
         end
      end
      @(negedge clk);
      rd(A_STAT, 2'b00, v);
      check_eq("post_frame_status", v, 32'h4);
   endtask

   // serial monitor: captures every frame and checks it against the scoreboard
   initial begin : monitor
      logic prev;
      logic [FRAME-1:0] smp;
      logic [NBITS-1:0] got_bits;
      logic [NBITS-1:0] want;
      logic [7:0] eb;
      logic shape_ok;
      int ep;
      int c0;
      prev = 1'b1;
      forever begin
         @(negedge clk);
         if (reset && prev && !tx) begin
            ep     = rst_epoch;
            c0     = cyc;
            smp[0] = tx;
            for (int k = 1; k < FRAME; k++) begin
               @(negedge clk);
               smp[k] = tx;
            end
            prev = smp[FRAME-1];
            if (ep == rst_epoch) begin
               start_cyc.push_back(c0);
               shape_ok = 1'b1;
               for (int bi = 0; bi < NBITS; bi++) begin
                  got_bits[bi] = smp[bi*CPB];
                  for (int j = 1; j < CPB; j++)
                     if (smp[bi*CPB+j] !== smp[bi*CPB]) shape_ok = 1'b0;
               end
               if (exp_q.size() == 0) begin
                  check_eq("frame_unexpected", 32'(got_bits), 32'h0);
               end else begin
                  eb   = exp_q.pop_front();
                  want = frame_bits(eb);
                  check_eq($sformatf("frame_bits_%02h", eb), 32'(got_bits), 32'(want));
                  check_eq($sformatf("frame_bit_width_%02h", eb), 32'(shape_ok), 32'd1);
               end
            end
         end else begin
            prev = tx;
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "simulation time limit exceeded");
   end

   initial begin : main
      logic [31:0] v;
      logic saw_low;
      repeat (3) @(negedge clk);
      reset = 1'b1;
      check_eq("reset_tx", 32'(tx), 32'd1);
      rd(A_STAT, 2'b00, v);
      check_eq("reset_status", v, 32'h4);

      rd(A_TXD, 2'b00, v);
      check_eq("rd_txd_zero", v, 32'h0);
      rd(A_OTHER, 2'b01, v);
      check_eq("rd_other_zero", v, 32'h0);
      rd(A_STAT, NOP, v);
      check_eq("rd_stat_nop_zero", v, 32'h0);
      rd(A_STAT, 2'b11, v);
      check_eq("rd_stat_op11", v, 32'h4);

      @(negedge clk);
      wave_check(8'h55);
      wait_drain(500);
`ifdef UART_PARITY_EN
      wave_check(8'h07);
      wait_drain(500);
`endif

      start_cyc.delete();
      for (int i = 1; i <= 6; i++) begin
         if (i <= 5) exp_q.push_back(8'(i));
         wr(A_TXD, 32'(i));
      end
      rd(A_STAT, 2'b00, v);
      check_eq("ovf_status", v & 32'hFFFF_FFFE, 32'h0000_040A);
      check_eq("ovf_busy", 32'(v[0]), 32'd1);
      wr(A_STAT, 32'h0000_FFFF);
      rd(A_STAT, 2'b00, v);
      check_eq("ovf_cleared", v, 32'h0000_0403);
      wait_drain(2000);
      check_eq("ovf_frames", 32'(start_cyc.size()), 32'd5);
      for (int i = 1; i < start_cyc.size(); i++)
         check_eq($sformatf("frame_gap_%0d", i), 32'(start_cyc[i] - start_cyc[i-1]), 32'(FRAME + 1));
      rd(A_STAT, 2'b00, v);
      check_eq("drain_status", v, 32'h4);

      start_cyc.delete();
      exp_q.push_back(8'hA5);
      wr(A_TXD, 32'hA5);
      exp_q.push_back(8'h11);
      wr(A_TXD, 32'h11);
      exp_q.push_back(8'h22);
      wr(A_TXD, 32'h22);
      repeat (16) @(negedge clk);
      check_eq("pre_reset_bit3", 32'(tx), 32'd0);
      rd(A_STAT, 2'b00, v);
      check_eq("pre_reset_status", v, 32'h0000_0201);
      rst_epoch++;
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      exp_q.delete();
      check_eq("abort_tx", 32'(tx), 32'd1);
      rd(A_STAT, 2'b00, v);
      check_eq("abort_status", v, 32'h4);
      saw_low = 1'b0;
      repeat (100) begin
         @(negedge clk);
         if (tx !== 1'b1) saw_low = 1'b1;
      end
      check_eq("abort_quiet", 32'(saw_low), 32'd0);
      check_eq("abort_no_frames", 32'(start_cyc.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/uart_tx_mmio.md
Name: uart_tx_mmio

Overview:
- Memory-mapped UART transmitter peripheral that answers the CPU data bus: addr, wdata, rdop, wrop, rdata.
- CPU stores bytes into a small TX FIFO; an FSM serializes them onto Tx_Serial as 8N1, LSB first.
- Status register is readable so software can poll.
- Sits beside the LED and BCD registers in the system top; its rdata is muxed in when its addresses are hit.

Parameters:
- CLKS_PER_BIT, 868, clock cycles per UART bit (100 MHz / 115200); must be ≥2.
- FIFO_AW, 2, FIFO address width; depth = 2**FIFO_AW = 4.
- ADDR_TXD, 32'h40000018, write-only data register; writing pushes wdata[7:0].
- ADDR_STAT, 32'h4000001C, status register; read returns status, write clears overflow.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-low reset.
- addr  in  32  CPU byte address.
- wdata  in  32  CPU store data.
- rdop  in  2  read op; 2'b10 = no read, any other value = read.
- wrop  in  2  write op; 2'b10 = no write, any other value = write.
- rdata  out  32  read data, combinational.
- Tx_Serial  out  1  UART line, idles high.

Behaviour:
- Reset (reset==0 at a clk edge):
  - FIFO emptied; overflow flag cleared.
  - FSM goes to IDLE; baud and bit counters cleared.
  - Tx_Serial=1 from the cycle after that edge.
  - Reset mid-frame aborts the frame; no partial bits resume.
- Bus decode:
  - wr_txd = (addr==ADDR_TXD) && wrop!=2'b10.
  - wr_stat = (addr==ADDR_STAT) && wrop!=2'b10.
- rdata, combinational:
  - Status word when rdop!=2'b10 and addr==ADDR_STAT.
  - Otherwise 32'b0. TXD reads return 0.
- Status word bits:
  - [0] busy (FSM != IDLE).
  - [1] fifo_full.
  - [2] fifo_empty.
  - [3] overflow (sticky).
  - [FIFO_AW+8:8] fifo count.
  - All other bits 0.
- Push:
  - On wr_txd with the FIFO not full (pre-edge state), wdata[7:0] is written at the edge.
  - On wr_txd with the FIFO full, the data is dropped and overflow is set. This holds even if a pop happens in the same cycle.
- Overflow clear: wr_stat clears overflow. If the same edge also sets overflow, set wins. (Both cannot target the same address in one cycle, so this case is defensive only.)
- Push and pop in the same cycle (not full): both happen; count is unchanged.
- Pointers: wrap modulo 2**FIFO_AW; count is FIFO_AW+1 bits wide.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: Tx=1. If the FIFO is non-empty, pop the head into an 8-bit shift register and go to START.
  - START: Tx=0 for CLKS_PER_BIT cycles, then DATA with bit index 0.
  - DATA: Tx=shift[0] for CLKS_PER_BIT cycles per bit; shift right after each bit; after bit 7 go to STOP.
  - STOP: Tx=1 for CLKS_PER_BIT cycles, then IDLE.
- Timing:
  - A byte written at edge N has its start bit on Tx from edge N+1 onward (when IDLE and the FIFO was empty).
  - Frame length is 10*CLKS_PER_BIT cycles.
  - Consecutive frames are separated by exactly one IDLE cycle (Tx=1).
- Baud counter: counts 0..CLKS_PER_BIT-1 and is cleared on every state or bit change.

Optional Feature:
- Macro: UART_PARITY_EN.
- Defined: state PARITY is inserted between DATA and STOP.
  - Tx = XOR of the 8 data bits (even parity) for CLKS_PER_BIT cycles.
  - Frame = 11*CLKS_PER_BIT.
- Undefined: no PARITY state; 8N1 frame of 10*CLKS_PER_BIT.
- Register map is identical either way.

Decomposition:
- Shared constants go in defs.v:
  - BUS_NOP 2'b10.
  - UART_TXD_ADDR, UART_STAT_ADDR.
  - FSM state encodings (3-bit, so PARITY fits).
  - Status bit positions.
- One sub-module: uart_fifo.
  - Synchronous FIFO, 8-bit wide, parameter AW.
  - Ports: clk, reset, push, pop, din, dout, full, empty, count.
  - dout is the head, visible combinationally.

Test Plan (bench uses CLKS_PER_BIT=4, FIFO_AW=2):
- Single byte: write 32'h55 to 40000018 → Tx low for 4 cycles from edge N+1, then 1,0,1,0,1,0,1,0 (4 cycles each), then high 4 cycles. Frame 40 cycles; status busy=1 during the frame, 0 after.
- Overflow: 6 back-to-back writes 0x01–0x06 → 0x06 dropped; status reads 32'h0000_040A (count=4, overflow, full). Bytes 0x01–0x05 are sent in order with one idle cycle between frames.
- Overflow clear: write any value to 4000001C → bit3 reads 0 the next cycle; FIFO is unaffected.
- Readback isolation: read 40000018 or 4000000C → rdata=0. Read 4000001C with rdop=2'b10 → rdata=0. Idle status after reset = 32'h0000_0004.
- Reset mid-frame: assert reset=0 for one edge during bit 3 of 0xA5 with 2 bytes queued → Tx=1 next cycle, status=32'h4, nothing further transmitted.
- UART_PARITY_EN defined: write 0x07 → parity bit=1 after the data bits; frame is 44 cycles.
